// File: rtl/pc_stack_unit_if.sv
// Control and status bundle between the instruction decoder and the program counter unit.
// Latency: none of its own; it only groups wires.
// Backpressure: none; stall is the only hold mechanism and it has no handshake.
interface pc_stack_unit_if #(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4,
    parameter int OFFS_W      = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic              stall;
    logic              jump_en;
    logic              branch_en;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] target;
    logic [OFFS_W-1:0] offset;
    logic [ADDR_W-1:0] pc;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_full;
    logic              overflow_err;
    logic              underflow_err;

    // Decoder side: issues commands, observes the counter and stack state.
    modport master (
        output stall, jump_en, branch_en, call_en, ret_en, target, offset,
        input  pc, stack_level, stack_full, overflow_err, underflow_err
    );

    // Program counter side.
    modport slave (
        input  stall, jump_en, branch_en, call_en, ret_en, target, offset,
        output pc, stack_level, stack_full, overflow_err, underflow_err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch, call/return stack, stall and sticky stack-error flags.
// Latency: one cycle; the command sampled at a rising edge is visible on pc/stack_level right after it.
// Backpressure: stall holds all state and discards the presented command; nothing is queued.
module pc_stack_unit #(
    parameter int                  ADDR_W      = 5,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   RESET_ADDR  = '0,
    parameter int                  OFFS_W      = 4
) (
    input logic          clk,
    input logic          rst,
    pc_stack_unit_if.slave bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_top;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              push;
    logic              full;
    logic signed [ADDR_W-1:0] offs_ext;

    // Sign-extending size cast; the add below wraps modulo 2^ADDR_W in both directions.
    assign offs_ext = ADDR_W'($signed(bus.offset));
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign full     = (level_q == LVL_W'(STACK_DEPTH));

    // Select the top-of-stack entry (entry level-1); value is unused when the stack is empty.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level_q == LVL_W'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    // Next-state decode; priority is stall > ret > call > jump > branch > increment.
    always_comb begin
        pc_d    = pc_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (!bus.stall) begin
            if (bus.ret_en) begin
                if (level_q != '0) begin
                    pc_d    = stack_top;
                    level_d = level_q - LVL_W'(1);
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (bus.call_en) begin
                if (full) begin
                    ovf_d = 1'b1;
                    pc_d  = pc_inc;
                end else begin
                    push    = 1'b1;
                    level_d = level_q + LVL_W'(1);
                    pc_d    = bus.target;
                end
            end else if (bus.jump_en) begin
                pc_d = bus.target;
            end else if (bus.branch_en) begin
                pc_d = pc_q + offs_ext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Counter, stack level and sticky flags; synchronous active-low reset wins over stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_ADDR;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage: only the slot just above the current top is ever written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && (level_q == LVL_W'(i))) begin
                stack_q[i] <= pc_inc;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.stack_level   = level_q;
    assign bus.stack_full    = full;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with default parameters.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: stall is exercised as a directed step.
module tb_pc_stack_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_stack_unit_if #(.ADDR_W(5), .STACK_DEPTH(4), .OFFS_W(4)) bus ();

    pc_stack_unit #(
        .ADDR_W(5), .STACK_DEPTH(4), .RESET_ADDR(5'd0), .OFFS_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.jump_en   = 1'b0;
        bus.branch_en = 1'b0;
        bus.call_en   = 1'b0;
        bus.ret_en    = 1'b0;
        bus.target    = '0;
        bus.offset    = '0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int pc, input int lvl,
                             input int ovf, input int unf);
        chk({tag, "_pc"},  int'(bus.pc), pc);
        chk({tag, "_lvl"}, int'(bus.stack_level), lvl);
        chk({tag, "_ovf"}, int'(bus.overflow_err), ovf);
        chk({tag, "_unf"}, int'(bus.underflow_err), unf);
    endtask

    task automatic do_jump(input int t);
        idle();
        bus.jump_en = 1'b1;
        bus.target  = 5'(t);
        tick();
        idle();
    endtask

    task automatic do_branch(input logic [3:0] off);
        idle();
        bus.branch_en = 1'b1;
        bus.offset    = off;
        tick();
        idle();
    endtask

    task automatic do_call(input int t);
        idle();
        bus.call_en = 1'b1;
        bus.target  = 5'(t);
        tick();
        idle();
    endtask

    task automatic do_ret();
        idle();
        bus.ret_en = 1'b1;
        tick();
        idle();
    endtask

    // Directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b0;
        tick();
        chk_state("reset", 0, 0, 0, 0);
        chk("reset_full", int'(bus.stack_full), 0);
        rst = 1'b1;

        // Free-running count across the 31 -> 0 wrap.
        for (int i = 1; i <= 33; i++) begin
            tick();
            chk("count", int'(bus.pc), i % 32);
        end
        for (int i = 0; i < 16; i++) tick();
        chk("count17", int'(bus.pc), 17);
        rst = 1'b0;
        tick();
        chk_state("midreset", 0, 0, 0, 0);
        rst = 1'b1;

        // Relative branches, both wrap directions.
        do_jump(10);
        chk("jump10", int'(bus.pc), 10);
        do_branch(4'b1101);
        chk("br_m3", int'(bus.pc), 7);
        do_jump(30);
        do_branch(4'd5);
        chk("br_p5_wrap", int'(bus.pc), 3);
        do_jump(1);
        do_branch(4'b1100);
        chk("br_m4_wrap", int'(bus.pc), 29);

        // Simple call / return.
        do_jump(5);
        do_call(20);
        chk_state("call20", 20, 1, 0, 0);
        tick();
        tick();
        chk("idle22", int'(bus.pc), 22);
        do_ret();
        chk_state("ret6", 6, 0, 0, 0);

        // Nested calls up to full, overflow, then unwind.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        do_call(21);
        chk_state("nest1", 21, 1, 0, 0);
        do_call(25);
        do_call(28);
        do_call(3);
        chk_state("nest4", 3, 4, 0, 0);
        chk("nest4_full", int'(bus.stack_full), 1);
        do_call(9);
        chk_state("overflow", 4, 4, 1, 0);
        do_ret();
        chk_state("unw1", 29, 3, 1, 0);
        chk("unw1_full", int'(bus.stack_full), 0);
        do_ret();
        chk_state("unw2", 26, 2, 1, 0);
        do_ret();
        chk_state("unw3", 22, 1, 1, 0);
        do_ret();
        chk_state("unw4", 1, 0, 1, 0);

        // Underflow is sticky through later valid call/ret.
        do_jump(12);
        do_ret();
        chk_state("underflow", 13, 0, 1, 1);
        do_call(2);
        chk_state("uf_call", 2, 1, 1, 1);
        do_ret();
        chk_state("uf_ret", 14, 0, 1, 1);
        rst = 1'b0;
        tick();
        chk_state("flag_clear", 0, 0, 0, 0);
        rst = 1'b1;

        // Priority resolution.
        do_call(8);
        chk_state("pri_setup", 8, 1, 0, 0);
        bus.ret_en    = 1'b1;
        bus.call_en   = 1'b1;
        bus.jump_en   = 1'b1;
        bus.branch_en = 1'b1;
        bus.target    = 5'd15;
        bus.offset    = 4'd3;
        tick();
        idle();
        chk_state("ret_wins", 1, 0, 0, 0);
        bus.call_en = 1'b1;
        bus.jump_en = 1'b1;
        bus.target  = 5'd10;
        tick();
        idle();
        chk_state("call_wins", 10, 1, 0, 0);
        bus.jump_en   = 1'b1;
        bus.branch_en = 1'b1;
        bus.target    = 5'd7;
        bus.offset    = 4'd1;
        tick();
        idle();
        chk("jump_wins", int'(bus.pc), 7);

        // Stall discards commands and holds everything.
        bus.stall   = 1'b1;
        bus.call_en = 1'b1;
        bus.target  = 5'd19;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("stall", 7, 1, 0, 0);
        end
        idle();
        tick();
        chk_state("post_stall", 8, 1, 0, 0);

        // Reset overrides stall.
        bus.stall = 1'b1;
        rst = 1'b0;
        tick();
        chk_state("rst_stall", 0, 0, 0, 0);
        rst = 1'b1;
        idle();
        tick();
        chk("after_rst", int'(bus.pc), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter with relative branches, a hardware call/return stack, stall, and sticky stack-error flags. It sits between the instruction decoder, which drives the control inputs, and instruction memory, which is addressed by `pc`. It generalises the plain increment/absolute-jump counter so the decoder can support subroutines and position-relative code.

## Interface
Parameters:
- `ADDR_W`, 5, width of the instruction address and of `pc`.
- `STACK_DEPTH`, 4, number of return-address entries (≥1).
- `RESET_ADDR`, 0, value loaded into `pc` on reset (ADDR_W bits).
- `OFFS_W`, 4, width of the signed branch offset (≤ADDR_W).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold all state this cycle; overrides every command.
- `jump_en`  in  1  absolute jump to `target`.
- `branch_en`  in  1  relative branch: pc + sext(`offset`).
- `call_en`  in  1  push pc+1, jump to `target`.
- `ret_en`  in  1  pop top of stack into pc.
- `target`  in  ADDR_W  absolute destination for jump/call.
- `offset`  in  OFFS_W  two's-complement branch offset.
- `pc`  out  ADDR_W  current instruction address (registered).
- `stack_level`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- `stack_full`  out  1  stack_level == STACK_DEPTH (combinational from level).
- `overflow_err`  out  1  sticky: call attempted while full.
- `underflow_err`  out  1  sticky: return attempted while empty.

## Operation
- Reset (`rst`=0 at edge): pc=RESET_ADDR, stack_level=0, both error flags 0, stack entry contents don't-care. Reset overrides `stall`.
- Command priority when several are asserted in one cycle: stall > ret > call > jump > branch > increment.
- Increment (no command): pc ← pc+1 mod 2^ADDR_W. Max address wraps to 0.
- Jump: pc ← target.
- Branch: pc ← (pc + sign-extend(offset)) mod 2^ADDR_W. The result is truncated to ADDR_W bits, so wrap occurs in both directions.
- Call, not full: stack[level] ← pc+1 (wrapped), level+1, pc ← target.
- Call while full: no push, level unchanged, overflow_err ← 1, pc ← pc+1 (call treated as no-op).
- Return, level>0: pc ← stack[level-1], level-1.
- Return while empty: underflow_err ← 1, pc ← pc+1.
- Stall: pc, stack, level and flags are all held. Commands presented during a stall are discarded, not queued.
- Error flags clear only on reset. They never block later valid commands.
- Stack is LIFO of registers; no entry is read or written except at the top.

## Timing
- Single-cycle: the command sampled at edge N is reflected in `pc`/`stack_level` immediately after edge N. No pipeline, no handshake.
- `pc` is a register output; there is no combinational path from inputs to `pc`.
- `stack_full` is combinational from the `stack_level` register only.
- Error flags assert in the same edge as the offending command.
- Call then ret in consecutive cycles: the ret sees the entry written by the call (level already incremented).
- Reset deasserted at edge N: the first increment happens at edge N+1 if no command is asserted.

## Test plan
ADDR_W=5, STACK_DEPTH=4, RESET_ADDR=0, OFFS_W=4 unless noted.
- Reset then 33 idle cycles: pc = 0,1,…,31,0,1. Wraps at 31→0. Reset mid-count (pc=17) gives pc=0, level=0 next cycle.
- pc=10, branch offset=-3 (4'b1101) → pc=7. pc=30, offset=+5 → pc=3. pc=1, offset=-4 → pc=29.
- pc=5, call target=20 → pc=20, level=1. Idle 2 cycles (pc=22), ret → pc=6, level=0.
- Four nested calls from pc=0,21,…: level=4, stack_full=1. Fifth call target=9 → pc=prev+1, overflow_err=1, level=4. Four rets restore addresses in reverse order.
- Ret at level=0, pc=12 → pc=13, underflow_err=1. The flag holds through later valid call/ret and clears only on `rst`=0.
- Priority and stall: all of ret, call, jump and branch asserted with level=1 → ret wins. With stall=1 plus call for 3 cycles → pc, level and flags unchanged. `rst`=0 together with stall → reset applies.
